// File: rtl/nla_job_scheduler.sv
// rtl/nla_job_scheduler.sv - round-robin job scheduler for a shared nonlinear-approximation engine
// Optional feature macro: NLA_SCHED_TIMEOUT_EN (WAIT-state watchdog with error response)
module nla_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_LINES     = 4,
  parameter int FUNC_BITS      = 2,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*FUNC_BITS-1:0] req_func_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic                         cfg_we_i,
  input  logic [FUNC_BITS-1:0]         cfg_func_i,
  input  logic [ADDR_LINES-1:0]        cfg_base_i,
  input  logic [ADDR_LINES-1:0]        cfg_degree_i,
  input  logic                         eng_busy_i,
  input  logic                         eng_done_i,
  input  logic [DATA_W-1:0]            eng_result_i,
  output logic                         eng_start_o,
  output logic [ADDR_LINES-1:0]        eng_base_o,
  output logic [ADDR_LINES-1:0]        eng_degree_o,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id_o,
  output logic [DATA_W-1:0]            resp_data_o,
  output logic                         resp_err_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = 1 << FUNC_BITS;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t                state;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       job_id;
  logic [ADDR_LINES-1:0] base_tbl [DEPTH];
  logic [ADDR_LINES-1:0] deg_tbl  [DEPTH];

  logic                  hi_any, lo_any, grant_any;
  logic [ID_W-1:0]       hi_idx, lo_idx, grant_idx;
  logic [FUNC_BITS-1:0]  grant_func;

`ifdef NLA_SCHED_TIMEOUT_EN
  logic [7:0]            wd_cnt;
  logic                  resp_err_q;
  assign resp_err_o = resp_err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  // Round-robin pick: lowest valid index above last_grant, else lowest valid index overall
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        lo_any = 1'b1;
        lo_idx = ID_W'(i);
        if (ID_W'(i) > last_grant) begin
          hi_any = 1'b1;
          hi_idx = ID_W'(i);
        end
      end
    end
    grant_any = lo_any;
    grant_idx = hi_any ? hi_idx : lo_idx;
  end

  // One-hot ready only while idle (and never while reset is held); select the winner's function ID
  always_comb begin
    req_ready_o = '0;
    grant_func  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_func     = req_func_i[i*FUNC_BITS +: FUNC_BITS];
        req_ready_o[i] = (state == S_IDLE) && rstn_i && grant_any;
      end
    end
  end

  // Launch pulse is issued in the first LAUNCH cycle in which the engine reports idle
  assign eng_start_o = (state == S_LAUNCH) && !eng_busy_i;

  // Function table; a job reads the pre-write value when a write hits its entry in the accept cycle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        base_tbl[i] <= '0;
        deg_tbl[i]  <= '0;
      end
    end else if (cfg_we_i) begin
      base_tbl[cfg_func_i] <= cfg_base_i;
      deg_tbl[cfg_func_i]  <= cfg_degree_i;
    end
  end

  // Job FSM: accept, launch, wait for engine result, hold response until consumed
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= S_IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      job_id       <= '0;
      eng_base_o   <= '0;
      eng_degree_o <= '0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= '0;
      resp_data_o  <= '0;
`ifdef NLA_SCHED_TIMEOUT_EN
      wd_cnt       <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            job_id       <= grant_idx;
            eng_base_o   <= base_tbl[grant_func];
            eng_degree_o <= deg_tbl[grant_func];
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (!eng_busy_i) begin
            state <= S_WAIT;
`ifdef NLA_SCHED_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (eng_done_i) begin
            resp_data_o  <= eng_result_i;
            resp_id_o    <= job_id;
            resp_valid_o <= 1'b1;
            state        <= S_RESP;
`ifdef NLA_SCHED_TIMEOUT_EN
            resp_err_q   <= 1'b0;
          end else if (wd_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            resp_data_o  <= '0;
            resp_id_o    <= job_id;
            resp_valid_o <= 1'b1;
            resp_err_q   <= 1'b1;
            state        <= S_RESP;
          end else if (wd_cnt != 8'hFF) begin
            wd_cnt <= wd_cnt + 8'd1;
`endif
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            last_grant   <= job_id;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nla_job_scheduler.sv
// tb/tb_nla_job_scheduler.sv - self-checking bench for nla_job_scheduler
module tb_nla_job_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid, req_ready;
  logic [7:0]  req_func;
  logic        cfg_we;
  logic [1:0]  cfg_func;
  logic [3:0]  cfg_base, cfg_degree;
  logic        eng_busy, eng_done, eng_start;
  logic [15:0] eng_result;
  logic [3:0]  eng_base, eng_degree;
  logic        resp_valid, resp_ready, resp_err;
  logic [1:0]  resp_id;
  logic [15:0] resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: arbitration pointer and function table
  int         model_last;
  logic [3:0] tbl_base [4];
  logic [3:0] tbl_deg  [4];

  always #5 clk = ~clk;

  nla_job_scheduler #(
    .NUM_REQ(4), .ADDR_LINES(4), .FUNC_BITS(2), .DATA_W(16), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_func_i(req_func), .req_ready_o(req_ready),
    .cfg_we_i(cfg_we), .cfg_func_i(cfg_func), .cfg_base_i(cfg_base), .cfg_degree_i(cfg_degree),
    .eng_busy_i(eng_busy), .eng_done_i(eng_done), .eng_result_i(eng_result),
    .eng_start_o(eng_start), .eng_base_o(eng_base), .eng_degree_o(eng_degree),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_data_o(resp_data), .resp_err_o(resp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] mask);
    for (int i = 1; i <= 4; i++)
      if (mask[(model_last + i) % 4]) return (model_last + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    model_last = 3;
    for (int i = 0; i < 4; i++) begin
      tbl_base[i] = 4'd0;
      tbl_deg[i]  = 4'd0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_base"}, 32'(eng_base), 32'd0);
    chk({tag, "_degree"}, 32'(eng_degree), 32'd0);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rid"}, 32'(resp_id), 32'd0);
    chk({tag, "_rdata"}, 32'(resp_data), 32'd0);
    chk({tag, "_rerr"}, 32'(resp_err), 32'd0);
  endtask

  task automatic cfg_write(input logic [1:0] f, input logic [3:0] b, input logic [3:0] d);
    tick();
    cfg_we = 1'b1; cfg_func = f; cfg_base = b; cfg_degree = d;
    tick();
    cfg_we = 1'b0;
    tbl_base[f] = b;
    tbl_deg[f]  = d;
  endtask

  // One complete job: accept, optional busy stall (with stray done pulses), engine latency, response hold
  task automatic do_job(input logic [3:0] mask, input logic [7:0] funcs, input int busy_n,
                        input int lat, input logic [15:0] res, input int hold_n,
                        input bit cw, input logic [3:0] cb, input logic [3:0] cd);
    int g, f;
    logic [3:0] eb, ed;
    tick();
    req_valid = mask; req_func = funcs;
    #1;
    g = model_grant(mask);
    f = int'((funcs >> (2 * g)) & 8'h3);
    chk("grant", 32'(req_ready), 32'(4'b0001 << g));
    eb = tbl_base[f];
    ed = tbl_deg[f];
    if (cw) begin
      cfg_we = 1'b1; cfg_func = 2'(f); cfg_base = cb; cfg_degree = cd;
    end
    tick();
    cfg_we = 1'b0; req_valid = 4'h0;
    if (cw) begin
      tbl_base[f] = cb;
      tbl_deg[f]  = cd;
    end
    for (int i = 0; i < busy_n; i++) begin
      eng_busy = 1'b1; eng_done = 1'b1; eng_result = 16'($urandom);
      req_valid = 4'hF;
      #1;
      chk("start_held", 32'(eng_start), 32'd0);
      chk("ready_launch", 32'(req_ready), 32'd0);
      tick();
    end
    eng_busy = 1'b0; eng_done = 1'b0; req_valid = 4'h0;
    #1;
    chk("start", 32'(eng_start), 32'd1);
    chk("base", 32'(eng_base), 32'(eb));
    chk("degree", 32'(eng_degree), 32'(ed));
    tick();
    #1;
    chk("start_once", 32'(eng_start), 32'd0);
    for (int i = 1; i < lat; i++) begin
      chk("resp_early", 32'(resp_valid), 32'd0);
      tick();
    end
    eng_done = 1'b1; eng_result = res;
    #1;
    chk("base_stable", 32'(eng_base), 32'(eb));
    chk("degree_stable", 32'(eng_degree), 32'(ed));
    tick();
    eng_done = 1'b0; eng_result = 16'($urandom);
    #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(g));
    chk("resp_data", 32'(resp_data), 32'(res));
    chk("resp_err", 32'(resp_err), 32'd0);
    for (int i = 0; i < hold_n; i++) begin
      resp_ready = 1'b0; req_valid = 4'hF;
      #1;
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_id", 32'(resp_id), 32'(g));
      chk("hold_data", 32'(resp_data), 32'(res));
      tick();
    end
    req_valid = 4'h0; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    model_last = g;
  endtask

  initial begin
    int g;
    rstn = 1'b0; req_valid = 4'h0; req_func = 8'h0;
    cfg_we = 1'b0; cfg_func = 2'd0; cfg_base = 4'd0; cfg_degree = 4'd0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_result = 16'h0; resp_ready = 1'b0;
    model_reset();
    tick(); tick();
    check_reset_outputs("reset");
    rstn = 1'b1;

    // Directed: func 2 = {5,3}; requester 1 requests func 2
    cfg_write(2'd2, 4'd5, 4'd3);
    do_job(4'b0010, 8'b0000_1000, 0, 1, 16'h1234, 0, 1'b0, 4'd0, 4'd0);

    // All requesters valid continuously: rotation 2,3,0,1,2 after requester 1
    for (int k = 0; k < 5; k++)
      do_job(4'hF, 8'($urandom), 0, 2, 16'($urandom), 0, 1'b0, 4'd0, 4'd0);

    // Engine busy for 5 cycles after accept
    do_job(4'b0001, 8'h02, 5, 3, 16'hBEEF, 0, 1'b0, 4'd0, 4'd0);

    // Collision write to the entry being accepted, then a later job sees the new values
    do_job(4'b0100, 8'h20, 0, 1, 16'h0F0F, 0, 1'b1, 4'd9, 4'd4);
    do_job(4'b0100, 8'h20, 0, 1, 16'hF0F0, 0, 1'b0, 4'd0, 4'd0);

    // Response held for 10 cycles with all requesters asking
    do_job(4'b1000, 8'h40, 0, 2, 16'hA5A5, 10, 1'b0, 4'd0, 4'd0);

    // Reset in the middle of WAIT
    tick();
    req_valid = 4'b0100; req_func = 8'h10;
    #1;
    g = model_grant(4'b0100);
    chk("rst_grant", 32'(req_ready), 32'(4'b0001 << g));
    tick();
    req_valid = 4'h0;
    #1;
    chk("rst_start", 32'(eng_start), 32'd1);
    tick(); tick();
    rstn = 1'b0;
    #1;
    check_reset_outputs("midwait");
    tick();
    rstn = 1'b1;
    model_reset();

    // Zeroed table after reset: degree 0 passes through; requester 0 wins first
    do_job(4'b0011, 8'h0D, 0, 1, 16'h7777, 0, 1'b0, 4'd0, 4'd0);

`ifdef NLA_SCHED_TIMEOUT_EN
    // Withheld done: error response after 20 WAIT cycles
    tick();
    req_valid = 4'b1000; req_func = 8'h00;
    #1;
    g = model_grant(4'b1000);
    chk("to_grant", 32'(req_ready), 32'(4'b0001 << g));
    tick();
    req_valid = 4'h0;
    #1;
    chk("to_start", 32'(eng_start), 32'd1);
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("to_early", 32'(resp_valid), 32'd0);
      tick();
    end
    #1;
    chk("to_valid", 32'(resp_valid), 32'd1);
    chk("to_err", 32'(resp_err), 32'd1);
    chk("to_data", 32'(resp_data), 32'd0);
    chk("to_id", 32'(resp_id), 32'(g));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    model_last = g;
    do_job(4'b0001, 8'h00, 0, 2, 16'h4321, 0, 1'b0, 4'd0, 4'd0);
`endif

    // Randomized jobs against the reference model
    for (int f = 0; f < 4; f++)
      cfg_write(2'(f), 4'($urandom), 4'($urandom));
    for (int k = 0; k < 12; k++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      do_job(m, 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
             16'($urandom), int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
             4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
